// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fifo_reader_pkg;

  // Controller operating modes.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

  // Number of words the output skid buffer can hold.
  localparam int SKID_DEPTH = 2;

  // Width of the skid occupancy count (0..SKID_DEPTH).
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_skid.sv
// 2-entry in-order skid buffer holding words between FIFO capture and the consumer.
// Latency: a pushed word becomes the head (or queues behind it) on the next clock edge.
// Backpressure: none internally; the caller only pushes when a slot is guaranteed.
//
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_push, i_din   store i_din behind the current contents
//   i_pop           drop the head word
//   i_clear         discard everything (wins over push/pop)
//   o_head, o_occ   oldest stored word and number of stored words
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [W-1:0]     i_din,
  output logic [W-1:0]     o_head,
  output logic [OCC_W-1:0] o_occ
);

  logic [W-1:0]     r_mem0;  // head slot
  logic [W-1:0]     r_mem1;  // second slot
  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_occ  <= '0;
    end else if (i_clear) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_occ  <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == '0) r_mem0 <= i_din;
          else             r_mem1 <= i_din;
          r_occ <= r_occ + OCC_W'(1);
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_occ  <= r_occ - OCC_W'(1);
        end
        2'b11: begin
          // Head leaves while a new word arrives: occupancy stays, order kept.
          if (r_occ == OCC_W'(1)) begin
            r_mem0 <= i_din;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_mem0;
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: pops a synchronous FIFO and streams words out via valid/ready.
// Latency: Fifo_rd sampled at edge N, word captured at N+1, valid_out from then on.
// Backpressure: reads only while the skid can absorb them; at most 2 words leave the FIFO
//               while ready_in is low.
//
// Ports:
//   clk, reset              clock and asynchronous active-low reset
//   enable, flush           run permission (level) and flush request (pulse)
//   Fifo_empty, Fifo_rd     FIFO empty flag in, pop request out
//   Fifo_Data_out           FIFO data, valid the cycle after a pop
//   data_out, valid_out,
//   ready_in                downstream handshake
//   words_read              wrapping count of delivered words
//   flush_done              one-cycle pulse at the end of a flush
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int BITNUMBER = 8,
  parameter int LENGTH    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 Fifo_empty,
  input  logic [BITNUMBER-1:0] Fifo_Data_out,
  output logic                 Fifo_rd,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [CNT_W-1:0]     words_read,
  output logic                 flush_done
);

  localparam int FC_W = $clog2(LENGTH + 1);

  rd_state_t        r_state;
  logic             r_inflight;     // FIFO was popped last cycle; its word is on Fifo_Data_out now
  logic [CNT_W-1:0] r_words_read;
  logic             r_flush_done;
  logic [FC_W-1:0]  r_flush_reads;  // pops issued during the current flush

  logic [OCC_W-1:0] w_occ;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_clear;
  logic             w_room;
  logic             w_flush_cap;
  logic             w_flush_end;

  assign w_valid = (w_occ != '0) && (r_state != FLUSH);
  assign w_pop   = w_valid && ready_in;
  // Words arriving during a flush are dropped instead of captured.
  assign w_push  = r_inflight && (r_state != FLUSH);
  assign w_clear = flush && (r_state != FLUSH);

  // A new pop is safe only if the words already owed to the skid (stored plus in flight,
  // minus the one leaving now) leave a free slot for it.
  assign w_room = ({1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight})
                < ((OCC_W + 1)'(SKID_DEPTH) + {{OCC_W{1'b0}}, w_pop});

  // A flush never pops more than one FIFO's worth, so a writer that keeps
  // feeding the FIFO cannot hold the controller in FLUSH forever.
  assign w_flush_cap = (r_flush_reads == FC_W'(LENGTH));
  assign w_flush_end = (Fifo_empty || w_flush_cap) && !r_inflight;

  // enable also gates RUN-state reads so that dropping it stops reads in the same cycle.
  always_comb begin
    Fifo_rd = 1'b0;
    case (r_state)
      RUN:     Fifo_rd = enable && !Fifo_empty && w_room;
      FLUSH:   Fifo_rd = !Fifo_empty && !w_flush_cap;
      default: Fifo_rd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_inflight    <= 1'b0;
      r_words_read  <= '0;
      r_flush_done  <= 1'b0;
      r_flush_reads <= '0;
    end else begin
      r_inflight   <= Fifo_rd;
      r_flush_done <= 1'b0;
      if (w_pop) r_words_read <= r_words_read + CNT_W'(1);
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state       <= FLUSH;
            r_flush_reads <= '0;
          end else if (enable) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            r_state       <= FLUSH;
            r_flush_reads <= '0;
          end else if (!enable) begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          if (Fifo_rd) r_flush_reads <= r_flush_reads + FC_W'(1);
          if (w_flush_end) begin
            r_state      <= enable ? RUN : IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fifo_reader_skid #(
    .W (BITNUMBER)
  ) u_skid (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_din   (Fifo_Data_out),
    .o_head  (data_out),
    .o_occ   (w_occ)
  );

  assign valid_out  = w_valid;
  assign words_read = r_words_read;
  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader against a behavioural synchronous FIFO.
// Latency: n/a.
// Backpressure: driven directly through ready_in.
module tb_fifo_reader;

  localparam int BW  = 8;
  localparam int LEN = 8;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          ready_in = 1'b0;
  logic          Fifo_empty;
  logic          Fifo_rd;
  logic [BW-1:0] Fifo_Data_out = '0;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic [CW-1:0] words_read;
  logic          flush_done;

  int checks = 0;
  int failures = 0;

  fifo_reader #(.BITNUMBER(BW), .LENGTH(LEN), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .enable        (enable),
    .flush         (flush),
    .Fifo_empty    (Fifo_empty),
    .Fifo_Data_out (Fifo_Data_out),
    .Fifo_rd       (Fifo_rd),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .words_read    (words_read),
    .flush_done    (flush_done)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO with one-cycle read latency. Fifo_rd is captured at the
  // falling edge so the rising-edge pop never races the DUT's state update.
  logic [BW-1:0] fmem [0:63];
  int  frd = 0;
  int  fwr = 0;
  int  rd_cnt = 0;
  logic rd_s = 1'b0;

  assign Fifo_empty = (frd == fwr);

  always @(negedge clk) rd_s <= Fifo_rd;

  always @(posedge clk) begin
    if (rd_s && (frd != fwr)) begin
      Fifo_Data_out <= fmem[frd];
      frd <= frd + 1;
    end
    if (rd_s) rd_cnt <= rd_cnt + 1;
  end

  logic [BW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [BW-1:0] b, input bit expect_out);
    fmem[fwr] = b;
    fwr = fwr + 1;
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int target, input int max_cyc);
    int n;
    n = 0;
    while ((int'(words_read) != target) && (n < max_cyc)) begin
      step(1);
      n++;
    end
    chk("wait_words", 32'(words_read), 32'(target));
  endtask

  // Monitor: compares every delivered word with the scoreboard head.
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_data = '0;
  logic [BW-1:0] exp_w;

  always @(negedge clk) begin
    if (rst_n) begin
      if (Fifo_rd) chk("rd_while_empty", 32'(Fifo_empty), 32'd0);
      if (prev_stall && valid_out) chk("hold_data", 32'(data_out), 32'(prev_data));
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected none", data_out);
        end else begin
          exp_w = exp_q.pop_front();
          chk("data", 32'(data_out), 32'(exp_w));
        end
      end
      prev_stall <= valid_out && !ready_in;
      prev_data  <= data_out;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    int r0;
    int n;
    int cyc;
    int done_cnt;
    int first_done;

    // Reset with FIFO preloaded, enable low.
    load(8'hA1, 1'b1);
    load(8'hB2, 1'b1);
    load(8'hC3, 1'b1);
    step(2);
    chk("rst_rd", 32'(Fifo_rd), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_words", 32'(words_read), 32'd0);
    chk("rst_fdone", 32'(flush_done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("idle_rd", 32'(Fifo_rd), 32'd0);
      chk("idle_valid", 32'(valid_out), 32'd0);
    end
    chk("idle_words", 32'(words_read), 32'd0);

    // Streaming A,B,C,D at full rate.
    load(8'hD4, 1'b1);
    ready_in = 1'b1;
    enable = 1'b1;
    step(1);
    chk("lat_valid_e1", 32'(valid_out), 32'd0);
    step(1);
    chk("lat_valid_e2", 32'(valid_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stream_valid", 32'(valid_out), 32'd1);
    end
    step(1);
    chk("stream_end_valid", 32'(valid_out), 32'd0);
    chk("stream_words", 32'(words_read), 32'd4);
    chk("stream_rd_cnt", 32'(rd_cnt), 32'd4);

    // Backpressure: only two pops while stalled, head held.
    ready_in = 1'b0;
    r0 = rd_cnt;
    load(8'hA1, 1'b1);
    load(8'hB2, 1'b1);
    load(8'hC3, 1'b1);
    load(8'hD4, 1'b1);
    step(5);
    chk("bp_rd_pulses", 32'(rd_cnt - r0), 32'd2);
    chk("bp_valid", 32'(valid_out), 32'd1);
    chk("bp_head", 32'(data_out), 32'hA1);
    ready_in = 1'b1;
    wait_words(8, 20);
    step(2);
    chk("bp_rd_total", 32'(rd_cnt - r0), 32'd4);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Full FIFO, enable dropped after three deliveries.
    for (int i = 1; i <= LEN; i++) load(BW'(i), 1'b1);
    wait_words(11, 30);
    enable = 1'b0;
    step(6);
    n = int'(words_read) - 8;
    chk("dis_extra_le2", 32'((n >= 3) && (n <= 5)), 32'd1);
    chk("dis_valid", 32'(valid_out), 32'd0);
    chk("dis_fifo_left", 32'(Fifo_empty), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("dis_rd", 32'(Fifo_rd), 32'd0);
    end
    enable = 1'b1;
    wait_words(16, 30);
    step(2);
    chk("dis_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with a full skid and words still in the FIFO.
    ready_in = 1'b0;
    load(8'hEE, 1'b0);
    load(8'hFF, 1'b0);
    load(8'h01, 1'b0);
    load(8'h02, 1'b0);
    load(8'h03, 1'b0);
    load(8'h04, 1'b0);
    step(5);
    chk("pre_flush_valid", 32'(valid_out), 32'd1);
    chk("pre_flush_head", 32'(data_out), 32'hEE);
    r0 = rd_cnt;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_valid", 32'(valid_out), 32'd0);
    cyc = 1;
    done_cnt = 0;
    first_done = 0;
    for (int i = 0; i < LEN + 4; i++) begin
      step(1);
      cyc++;
      if (flush_done) begin
        done_cnt++;
        if (first_done == 0) first_done = cyc;
      end
    end
    chk("flush_done_once", 32'(done_cnt), 32'd1);
    chk("flush_len_ok", 32'((first_done > 0) && (first_done <= LEN + 2)), 32'd1);
    chk("flush_words", 32'(words_read), 32'd16);
    chk("flush_rd_cnt", 32'(rd_cnt - r0), 32'd4);
    chk("flush_empty", 32'(Fifo_empty), 32'd1);
    chk("flush_post_valid", 32'(valid_out), 32'd0);

    // Reset with a word in the skid and another in flight.
    load(8'h10, 1'b0);
    load(8'h11, 1'b0);
    load(8'h12, 1'b1);
    load(8'h13, 1'b1);
    step(2);
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    chk("pre_rst_head", 32'(data_out), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(Fifo_rd), 32'd0);
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_words", 32'(words_read), 32'd0);
    chk("mid_rst_fdone", 32'(flush_done), 32'd0);
    step(2);
    rst_n = 1'b1;
    ready_in = 1'b1;
    wait_words(2, 20);
    step(3);
    chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("post_rst_words", 32'(words_read), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
